// File: rtl/l3_arbiter.sv
// l3_arbiter: round-robin arbiter sharing the single L3 cache port among
// NUM_REQ requesters, one outstanding transaction at a time.
// Optional response watchdog: define L3_ARB_TIMEOUT_EN to enable the
// TIMEOUT-cycle abort in WAIT (rsp_err=1, rsp_data=0).
module l3_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      l3_valid,
    input  logic                      l3_ready,
    output logic                      l3_we,
    output logic [ADDR_W-1:0]         l3_addr,
    output logic [DATA_W-1:0]         l3_wdata,
    input  logic                      l3_rvalid,
    input  logic [DATA_W-1:0]         l3_rdata
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } l3_req_t;

    // Reject unsupported configurations at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("l3_arbiter: unsupported parameter set");
    end

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic               l3_valid_q, l3_valid_d;
    l3_req_t            l3_req_q, l3_req_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0] req_ready_c;

`ifdef L3_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 255) ? 16 : 8;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_err_q, rsp_err_d;
`endif

    l3_req_t            cand [NUM_REQ];
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     rr_idx;

    // Unpack the flattened requester buses into per-requester payloads.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign cand[i] = {req_we[i], req_addr[i*ADDR_W +: ADDR_W], req_wdata[i*DATA_W +: DATA_W]};
    end

    // Round-robin search: first valid requester at or after ptr, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rr_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (rr_idx >= (PTR_W+1)'(NUM_REQ)) begin
                rr_idx = rr_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[rr_idx[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_idx[PTR_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        l3_valid_d  = l3_valid_q;
        l3_req_d    = l3_req_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        req_ready_c = '0;
`ifdef L3_ARB_TIMEOUT_EN
        rsp_err_d   = 1'b0;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready_c = NUM_REQ'(1) << win_idx;
                    gnt_d       = win_idx;
                    l3_req_d    = cand[win_idx];
                    l3_valid_d  = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (l3_ready) begin
                    l3_valid_d = 1'b0;
                    state_d    = WAIT;
`ifdef L3_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            WAIT: begin
                if (l3_rvalid) begin
                    rsp_data_d  = l3_rdata;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    state_d     = RESP;
                end
`ifdef L3_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                ptr_d   = (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            l3_valid_q  <= 1'b0;
            l3_req_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef L3_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            l3_valid_q  <= l3_valid_d;
            l3_req_q    <= l3_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef L3_ARB_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Grant is combinational in IDLE and forced low while reset is held.
    assign req_ready = rst ? '0 : req_ready_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign l3_valid  = l3_valid_q;
    assign l3_we     = l3_req_q.we;
    assign l3_addr   = l3_req_q.addr;
    assign l3_wdata  = l3_req_q.wdata;
`ifdef L3_ARB_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
